fir_scie_sequencer: RTL
=======================

# fir_scie_sequencer

Sequencer that drives the FIR accelerator's SCIE instruction port (valid/insn/rs1/rs2 in, rd out) from two decoupled ready/valid streams: coefficient writes and input samples. It issues the load-coefficient, push-sample and read-result custom instructions in the correct order and spacing, then returns each filter result on a ready/valid output channel. It sits between a DMA or host-bridge front end and the FIR datapath, so the FIR can stream without a core hand-issuing instructions.

## Interface
- XLEN, 32, data width of rs1/rs2/rd and stream payloads
- NTAPS, 5, number of FIR coefficients; valid index range 0..NTAPS-1
- IDXW, $clog2(NTAPS), coefficient index width
- GAP_CYCLES, 1, idle cycles between PUSH and READ (min 0)
- RD_DELAY, 1, cycles from READ issue to fir_rd valid (min 1)
- OP_LOAD / OP_PUSH / OP_READ, 32'h0B / 32'h2B / 32'h5B, insn encodings

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_coef_valid / io_coef_ready  in/out  1  coefficient-write handshake
- io_coef_idx  in  IDXW  tap index
- io_coef_data  in  XLEN  coefficient value
- io_samp_valid / io_samp_ready  in/out  1  sample handshake
- io_samp_data  in  XLEN  sample value
- io_res_valid / io_res_ready  out/in  1  result handshake
- io_res_data  out  XLEN  filter result
- io_coef_err  out  1  sticky: an out-of-range index was received
- io_busy  out  1  state != IDLE
- fir_valid  out  1  instruction valid to FIR
- fir_insn  out  32  instruction word
- fir_rs1 / fir_rs2  out  XLEN  operands
- fir_rd  in  XLEN  FIR result

## Operation
- FSM states: IDLE, LOAD, PUSH, GAP, READ, WAIT.
- io_coef_ready = (state==IDLE). io_samp_ready = (state==IDLE) && !io_coef_valid && (!io_res_valid || io_res_ready). Coefficients take priority over samples.
- IDLE + coef handshake: idx < NTAPS -> LOAD; idx >= NTAPS -> io_coef_err set, stay IDLE, nothing issued.
- LOAD (1 cycle): fir_valid=1, insn=OP_LOAD, rs1=coef data, rs2=idx (zero-extended). -> IDLE.
- IDLE + samp handshake: latch sample -> PUSH.
- PUSH (1 cycle): fir_valid=1, insn=OP_PUSH, rs1=sample, rs2=0. -> GAP, or READ if GAP_CYCLES=0.
- GAP (GAP_CYCLES cycles, down-counter): fir_valid=0.
- READ (1 cycle): fir_valid=1, insn=OP_READ, rs1=rs2=0. -> WAIT.
- WAIT (RD_DELAY cycles): on the final WAIT cycle, register fir_rd into io_res_data, set io_res_valid. -> IDLE.
- io_res_valid clears on io_res_ready handshake. A new result is never written while the previous one is undelivered, which the samp_ready gating guarantees. Coefficient loads are allowed while a result is pending.
- In non-issuing states, fir_insn/rs1/rs2 hold their last values. Only fir_valid qualifies them.
- All fir_* outputs and io_res_* are registers. Ready outputs are combinational.

## Timing
- Reset values: state=IDLE, fir_valid=0, fir_insn=0, fir_rs1=0, fir_rs2=0, io_res_valid=0, io_res_data=0, io_coef_err=0, io_busy=0.
- Coef accepted in cycle t -> fir_valid with OP_LOAD in cycle t+1. Peak rate is one load per 2 cycles.
- Sample accepted in cycle t -> PUSH at t+1, READ at t+2+GAP_CYCLES, io_res_valid high from t+2+GAP_CYCLES+RD_DELAY+1. Defaults give t+5.
- The next sample is acceptable in the first cycle io_res_valid is high, provided io_res_ready is high that cycle.
- Simultaneous coef and samp valid in IDLE: the coef is accepted and the sample waits.
- Reset assertion mid-sequence: all registers clear immediately, and fir_valid drops without waiting for a clock. A partially issued PUSH/READ pair is abandoned. FIR internal state is not cleared by this block.
- io_coef_err is cleared only by reset.

## Test plan
- Reset: assert reset_n=0 mid-GAP -> fir_valid=0 and io_res_valid=0 at once. After release, first accept is at the next IDLE cycle, with all outputs at reset values.
- Coef load: idx 0..4 = 32,62,48,95,52 back-to-back -> five OP_LOAD issues, one every 2 cycles, rs1/rs2 matching, coef_ready low in each LOAD cycle.
- Sample stream (bench FIR model returns previous pushed sample): samples 43,30,60 -> results 0,43,30. Each PUSH→READ spacing is exactly 2 cycles, and res_valid is at t+5.
- Backpressure: hold io_res_ready=0 for 10 cycles with samp_valid=1 -> samp_ready=0, no fir_valid, res_data stable. Release -> result drained and next sample accepted the same cycle.
- Priority: coef_valid and samp_valid both asserted in IDLE -> OP_LOAD issued first, then OP_PUSH.
- Bad index: coef idx 7 (NTAPS=5) -> no fir_valid, io_coef_err=1 and sticky; subsequent valid loads proceed normally.

Source files
------------

// File: rtl/fir_scie_sequencer_if.sv
// Bundle of the host-side streams and the FIR SCIE instruction port driven by
// fir_scie_sequencer. The sequencer takes the slave view; host and FIR take the master view.
interface fir_scie_sequencer_if #(
  parameter int XLEN = 32,
  parameter int IDXW = 3
);
  logic            io_coef_valid;
  logic            io_coef_ready;
  logic [IDXW-1:0] io_coef_idx;
  logic [XLEN-1:0] io_coef_data;
  logic            io_samp_valid;
  logic            io_samp_ready;
  logic [XLEN-1:0] io_samp_data;
  logic            io_res_valid;
  logic            io_res_ready;
  logic [XLEN-1:0] io_res_data;
  logic            io_coef_err;
  logic            io_busy;
  logic            fir_valid;
  logic [31:0]     fir_insn;
  logic [XLEN-1:0] fir_rs1;
  logic [XLEN-1:0] fir_rs2;
  logic [XLEN-1:0] fir_rd;

  modport master (
    output io_coef_valid, io_coef_idx, io_coef_data,
    output io_samp_valid, io_samp_data, io_res_ready, fir_rd,
    input  io_coef_ready, io_samp_ready, io_res_valid, io_res_data,
    input  io_coef_err, io_busy, fir_valid, fir_insn, fir_rs1, fir_rs2
  );

  modport slave (
    input  io_coef_valid, io_coef_idx, io_coef_data,
    input  io_samp_valid, io_samp_data, io_res_ready, fir_rd,
    output io_coef_ready, io_samp_ready, io_res_valid, io_res_data,
    output io_coef_err, io_busy, fir_valid, fir_insn, fir_rs1, fir_rs2
  );
endinterface

// File: rtl/fir_scie_sequencer.sv
// Issues LOAD / PUSH / READ custom instructions to the FIR accelerator from
// coefficient and sample streams, and returns each filter result on a ready/valid channel.
module fir_scie_sequencer #(
  parameter int          XLEN       = 32,
  parameter int          NTAPS      = 5,
  parameter int          IDXW       = (NTAPS > 1) ? $clog2(NTAPS) : 1,
  parameter int          GAP_CYCLES = 1,
  parameter int          RD_DELAY   = 1,
  parameter logic [31:0] OP_LOAD    = 32'h0B,
  parameter logic [31:0] OP_PUSH    = 32'h2B,
  parameter logic [31:0] OP_READ    = 32'h5B
) (
  input  logic clock,
  input  logic reset_n,
  fir_scie_sequencer_if.slave bus
);

  localparam int CNT_MAX = (GAP_CYCLES > RD_DELAY) ? GAP_CYCLES : RD_DELAY;
  localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNTW-1:0] WAIT_LOAD = CNTW'(RD_DELAY - 1);
  localparam logic [IDXW:0]   NTAPS_W   = (IDXW + 1)'(NTAPS);
  localparam bit              NO_GAP    = (GAP_CYCLES == 0);

  typedef enum logic [2:0] {IDLE, LOAD, PUSH, GAP, READ, WAIT} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            coef_fire;
  logic            samp_fire;
  logic            idx_ok;

  // Sample intake is held off while a result is undelivered, so WAIT never overwrites it.
  assign bus.io_coef_ready = (state == IDLE);
  assign bus.io_samp_ready = (state == IDLE) && !bus.io_coef_valid &&
                             (!bus.io_res_valid || bus.io_res_ready);
  assign bus.io_busy       = (state != IDLE);
  assign coef_fire         = bus.io_coef_valid && bus.io_coef_ready;
  assign samp_fire         = bus.io_samp_valid && bus.io_samp_ready;
  assign idx_ok            = ({1'b0, bus.io_coef_idx} < NTAPS_W);

  // fir_* registers are loaded on entry to the issuing state, so they are valid during it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.fir_valid    <= 1'b0;
      bus.fir_insn     <= '0;
      bus.fir_rs1      <= '0;
      bus.fir_rs2      <= '0;
      bus.io_res_valid <= 1'b0;
      bus.io_res_data  <= '0;
      bus.io_coef_err  <= 1'b0;
    end else begin
      if (bus.io_res_valid && bus.io_res_ready) begin
        bus.io_res_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (coef_fire) begin
            if (idx_ok) begin
              bus.fir_valid <= 1'b1;
              bus.fir_insn  <= OP_LOAD;
              bus.fir_rs1   <= bus.io_coef_data;
              bus.fir_rs2   <= {{(XLEN - IDXW){1'b0}}, bus.io_coef_idx};
              state         <= LOAD;
            end else begin
              bus.io_coef_err <= 1'b1;
            end
          end else if (samp_fire) begin
            bus.fir_valid <= 1'b1;
            bus.fir_insn  <= OP_PUSH;
            bus.fir_rs1   <= bus.io_samp_data;
            bus.fir_rs2   <= '0;
            state         <= PUSH;
          end
        end
        LOAD: begin
          bus.fir_valid <= 1'b0;
          state         <= IDLE;
        end
        PUSH: begin
          if (NO_GAP) begin
            bus.fir_valid <= 1'b1;
            bus.fir_insn  <= OP_READ;
            bus.fir_rs1   <= '0;
            bus.fir_rs2   <= '0;
            state         <= READ;
          end else begin
            bus.fir_valid <= 1'b0;
            cnt           <= GAP_LOAD;
            state         <= GAP;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            bus.fir_valid <= 1'b1;
            bus.fir_insn  <= OP_READ;
            bus.fir_rs1   <= '0;
            bus.fir_rs2   <= '0;
            state         <= READ;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        READ: begin
          bus.fir_valid <= 1'b0;
          cnt           <= WAIT_LOAD;
          state         <= WAIT;
        end
        WAIT: begin
          // fir_rd is sampled on the last WAIT cycle, RD_DELAY cycles after READ.
          if (cnt == '0) begin
            bus.io_res_data  <= bus.fir_rd;
            bus.io_res_valid <= 1'b1;
            state            <= IDLE;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        default: begin
          bus.fir_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
